apb_reg_completer: RTL
======================

// Module: apb_reg_completer
// PURPOSE
// - APB4 completer (slave) register bank: answers APB transfers from an APB requester.
// - Holds NREGS registers of DATA bits and supports byte-strobed writes, reads and programmable wait states.
// - Flags PSLVERR on bad addresses.
// - Register contents drive DMA/harness control logic.
// - Address/data widths come from apb_param_pkg (ADDR, DATA, STRB_t).
// PARAMETERS
// - ADDR         apb_param_pkg::ADDR  paddr width
// - DATA         apb_param_pkg::DATA  register/data width; must be 32 or 64
// - NREGS        8                    number of registers; word-addressed from offset 0
// - WAIT_CYCLES  0                    PREADY-low cycles inserted in each access phase (0..15)
// - RESET_VAL    '0                   reset value of every register
// PORTS
// - pclk      in   1             APB clock; everything on rising edge
// - preset    in   1             synchronous, active-high reset
// - psel      in   1             completer select
// - penable   in   1             access phase
// - pwrite    in   1             1 = write, 0 = read
// - paddr     in   ADDR          byte address
// - pwdata    in   DATA          write data
// - pstrb     in   DATA/8        byte write strobes
// - pprot     in   3             protection; present only with APB_REG_PROT_EN
// - prdata    out  DATA          read data, valid when pready & ~pwrite
// - pready    out  1             transfer completion
// - pslverr   out  1             error response, valid when pready
// - reg_q     out  NREGS*DATA    flattened register contents; reg i = [i*DATA +: DATA]
// - reg_wr    out  NREGS         1-cycle pulse on the cycle after register i is written
// BEHAVIOUR
// - Reset: synchronous, active-high (preset=1 at a pclk edge).
//   - All registers = RESET_VAL; FSM = IDLE; wait counter = 0; pready=0, pslverr=0, prdata=0, reg_wr=0.
//   - Reset mid-transfer aborts it with no write.
// - FSM states: IDLE, ACCESS.
//   - IDLE -> ACCESS when psel & ~penable (setup phase); wait counter loads WAIT_CYCLES.
//   - ACCESS: counter decrements each cycle while nonzero.
//   - ACCESS, cnt==0: pready=1 (combinational from state/cnt); completes and returns to IDLE next cycle.
//   - ACCESS with psel=0 (requester protocol violation): return to IDLE, no write, no response.
// - Latency: WAIT_CYCLES=0 completes in the first access cycle (zero-wait APB). Otherwise WAIT_CYCLES cycles with pready=0, then completion.
// - Back-to-back transfers: the completion cycle is followed directly by the next setup cycle with no idle gap.
// - Decode: LSB = log2(DATA/8); idx = paddr[ADDR-1:LSB]; off = paddr[LSB-1:0].
// - err = (idx >= NREGS) | (off != 0). pslverr = err & pready; pslverr=0 otherwise.
// - Write commits on the completion cycle only, if pwrite & ~err:
//   - reg[idx] byte b <= pwdata byte b for each pstrb[b]=1.
//   - pstrb == 0: no change, no error, reg_wr still pulses.
//   - Errored writes do not modify anything.
// - Read: prdata = reg[idx] on the completion cycle; prdata = 0 on error and in all non-completion cycles. pstrb is ignored on reads.
// - reg_wr[idx] is a registered pulse, high exactly one cycle after the commit edge.
// - Inputs are sampled only on the completion cycle: paddr/pwrite/pwdata changes during wait cycles follow the value on that cycle.
// CONFIGURATION
// - APB_REG_PROT_EN defined:
//   - pprot port exists.
//   - Writes with pprot[0]=0 (unprivileged) to any register -> pslverr=1, no write.
//   - Reads are unaffected.
// - APB_REG_PROT_EN undefined:
//   - No pprot port; all accesses are treated as privileged.
// TESTING
// - Reset, then read all 8 regs (DATA=32, RESET_VAL=0) -> prdata=0, pslverr=0, pready in 1st access cycle.
// - Write 0xDEADBEEF to 0x08 with pstrb=4'b0101, then read 0x08 -> 0x00AD00EF. reg_wr[2] pulses once, one cycle after commit.
// - WAIT_CYCLES=3; write 0x12345678 to 0x04 -> pready low for 3 access cycles, high on the 4th; reg1=0x12345678.
// - Write to 0x20 (idx 8) and to 0x05 (misaligned) -> pslverr=1 with pready; no reg change; no reg_wr; read of 0x20 -> prdata=0, pslverr=1.
// - Assert preset in a WAIT_CYCLES=3 write access -> no write. Next cycle pready=0 and FSM=IDLE; a following read returns RESET_VAL.
// - APB_REG_PROT_EN: write 0xA5A5A5A5 to 0x00 with pprot=3'b000 -> pslverr=1, reg0 unchanged. With pprot=3'b001 -> ok, reg0=0xA5A5A5A5.

Source files
------------

// File: rtl/apb_reg_completer.sv
// APB4 completer register bank with byte strobes, programmable wait states and PSLVERR decode.
// Optional APB_REG_PROT_EN adds pprot and rejects unprivileged writes.
package apb_param_pkg;
    localparam int ADDR = 12;
    localparam int DATA = 32;
    typedef logic [DATA/8-1:0] STRB_t;
endpackage

module apb_reg_slot #(
    parameter int              DATA      = 32,
    parameter logic [DATA-1:0] RESET_VAL = '0
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              we,
    input  logic [DATA-1:0]   wdata,
    input  logic [DATA/8-1:0] strb,
    output logic [DATA-1:0]   q
);
    always_ff @(posedge pclk) begin
        if (preset) begin
            q <= RESET_VAL;
        end else if (we) begin
            for (int b = 0; b < DATA/8; b++)
                if (strb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end
endmodule

module apb_reg_completer #(
    parameter int              ADDR        = apb_param_pkg::ADDR,
    parameter int              DATA        = apb_param_pkg::DATA,
    parameter int              NREGS       = 8,
    parameter int              WAIT_CYCLES = 0,
    parameter logic [DATA-1:0] RESET_VAL   = '0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR-1:0]       paddr,
    input  logic [DATA-1:0]       pwdata,
    input  logic [DATA/8-1:0]     pstrb,
`ifdef APB_REG_PROT_EN
    input  logic [2:0]            pprot,
`endif
    output logic [DATA-1:0]       prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [NREGS*DATA-1:0] reg_q,
    output logic [NREGS-1:0]      reg_wr
);
    localparam int LSB   = $clog2(DATA/8);
    localparam int IDX_W = ADDR - LSB;

    if (DATA != 32 && DATA != 64) begin : g_bad_data
        $error("apb_reg_completer: DATA must be 32 or 64");
    end

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic             wr;
        logic [IDX_W-1:0] idx;
        logic             err;
    } req_t;

    state_t                     state, state_nx;
    logic [3:0]                 cnt, cnt_nx;
    logic                       done;
    req_t                       req;
    logic [NREGS-1:0]           wr_en;
    logic [NREGS-1:0][DATA-1:0] regs;
    logic [DATA-1:0]            rd_word;
    logic                       prot_err;

`ifdef APB_REG_PROT_EN
    assign prot_err = pwrite & ~pprot[0];
`else
    assign prot_err = 1'b0;
`endif

    // Decode is combinational off the live bus, so only completion-cycle values matter.
    always_comb begin
        req.wr  = pwrite;
        req.idx = paddr[ADDR-1:LSB];
        req.err = (paddr[ADDR-1:LSB] >= IDX_W'(NREGS)) | (paddr[LSB-1:0] != '0) | prot_err;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state  <= IDLE;
            cnt    <= '0;
            reg_wr <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            reg_wr <= wr_en;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_nx = ACCESS;
                    cnt_nx   = 4'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                if (!psel) begin
                    // Requester abandoned the transfer: drop it silently.
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wr_en   = '0;
        rd_word = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (req.idx == IDX_W'(i)) begin
                wr_en[i] = done & req.wr & ~req.err;
                rd_word  = regs[i];
            end
        end
    end

    assign pready  = done;
    assign pslverr = done & req.err;
    assign prdata  = (done && !req.wr && !req.err) ? rd_word : '0;
    assign reg_q   = regs;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        apb_reg_slot #(.DATA(DATA), .RESET_VAL(RESET_VAL)) u_slot (
            .pclk   (pclk),
            .preset (preset),
            .we     (wr_en[i]),
            .wdata  (pwdata),
            .strb   (pstrb),
            .q      (regs[i])
        );
    end
endmodule
